// File: rtl/data_sram_resp.sv
// Responder end of the CPU data SRAM port: byte-writable word memory with range
// checking, access counters and a LATENCY-deep read response pipeline.
module data_sram_resp #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int unsigned ADDR_WORDS = 16384,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        acc_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt,
    output logic [31:0] err_cnt
);

    localparam int unsigned IDX_W    = $clog2(ADDR_WORDS);
    localparam logic [32:0] RANGE_LO = {1'b0, ADDR_BASE};
    localparam logic [32:0] RANGE_HI = RANGE_LO + (33'(ADDR_WORDS) << 2);

    if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
        $error("data_sram_resp: LATENCY must be 1..3");
    end

    logic [31:0]      mem [ADDR_WORDS];
    logic             is_read;
    logic             is_write;
    logic             in_range;
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             stage_v;
    logic [31:0]      stage_d;
    logic             tail_v;
    logic [31:0]      tail_d;
    logic             unused_offset;

    // Access classification; comparison done in 33 bits so the top of the range cannot wrap
    always_comb begin
        is_read  = data_sram_en && (data_sram_wen == 4'h0);
        is_write = data_sram_en && (data_sram_wen != 4'h0);
        in_range = ({1'b0, data_sram_addr} >= RANGE_LO) && ({1'b0, data_sram_addr} < RANGE_HI);
        offset   = data_sram_addr - ADDR_BASE;
        idx      = offset[IDX_W+1:2];
        stage_v  = is_read;
        stage_d  = in_range ? mem[idx] : 32'h0;
    end

    assign unused_offset = ^{offset[31:IDX_W+2], offset[1:0]};

    // Memory is deliberately outside reset so a write on the reset edge still lands
    always_ff @(posedge clk) begin
        if (is_write && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_err <= 1'b0;
            rd_cnt  <= 32'h0;
            wr_cnt  <= 32'h0;
            err_cnt <= 32'h0;
        end else if (data_sram_en) begin
            if (!in_range) begin
                acc_err <= 1'b1;
                err_cnt <= err_cnt + 32'd1;
            end else if (is_write) begin
                wr_cnt <= wr_cnt + 32'd1;
            end else begin
                rd_cnt <= rd_cnt + 32'd1;
            end
        end
    end

    // Stages ahead of the output register; the output register is the final stage
    if (LATENCY > 1) begin : g_pipe
        localparam int unsigned DEPTH = LATENCY - 1;
        logic [DEPTH-1:0] pv;
        logic [31:0]      pd [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                pv <= '0;
            end else begin
                pv[0] <= stage_v;
                for (int i = 1; i < DEPTH; i++) begin
                    pv[i] <= pv[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            pd[0] <= stage_d;
            for (int i = 1; i < DEPTH; i++) begin
                pd[i] <= pd[i-1];
            end
        end

        assign tail_v = pv[DEPTH-1];
        assign tail_d = pd[DEPTH-1];
    end else begin : g_direct
        assign tail_v = stage_v;
        assign tail_d = stage_d;
    end

    // Output data only moves on a strobe, so it holds between responses
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_valid     <= 1'b0;
            data_sram_rdata <= 32'h0;
        end else begin
            rdata_valid <= tail_v;
            if (tail_v) begin
                data_sram_rdata <= tail_d;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench: three responders (LATENCY 1, 2, 3) share one stimulus stream
// and are compared each cycle against a queue-free, edge-indexed behavioural model.
module tb_data_sram_resp;

    localparam int unsigned AW   = 64;
    localparam int          MAXE = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata   [3];
    logic        valid   [3];
    logic        acc_err [3];
    logic [31:0] rd_cnt  [3];
    logic [31:0] wr_cnt  [3];
    logic [31:0] err_cnt [3];

    always #5 clk = ~clk;

    data_sram_resp #(.ADDR_BASE(32'h0), .ADDR_WORDS(AW), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata[0]),
        .rdata_valid(valid[0]), .acc_err(acc_err[0]), .rd_cnt(rd_cnt[0]),
        .wr_cnt(wr_cnt[0]), .err_cnt(err_cnt[0]));

    data_sram_resp #(.ADDR_BASE(32'h0), .ADDR_WORDS(AW), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata[1]),
        .rdata_valid(valid[1]), .acc_err(acc_err[1]), .rd_cnt(rd_cnt[1]),
        .wr_cnt(wr_cnt[1]), .err_cnt(err_cnt[1]));

    data_sram_resp #(.ADDR_BASE(32'h0), .ADDR_WORDS(AW), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata[2]),
        .rdata_valid(valid[2]), .acc_err(acc_err[2]), .rd_cnt(rd_cnt[2]),
        .wr_cnt(wr_cnt[2]), .err_cnt(err_cnt[2]));

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bytemask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Model: reference memory with per-byte "known" tracking; responses scheduled by due edge
    logic [31:0] mmem   [AW];
    logic [3:0]  mknown [AW];
    logic        ev [3][MAXE];
    logic [31:0] ed [3][MAXE];
    logic [3:0]  em [3][MAXE];
    logic        e_valid [3];
    logic [31:0] e_data  [3];
    logic [3:0]  e_mask  [3];
    logic        e_acc;
    logic [31:0] e_rd, e_wr, e_err;
    int          edge_n = 0;
    bit          started = 0;

    task automatic model_edge();
        bit inr;
        int widx;
        int due;
        edge_n++;
        if (edge_n + 3 >= MAXE) begin
            $display("FAIL model_capacity: got %0d expected below %0d", edge_n, MAXE - 3);
            $fatal(1, "model capacity exceeded");
        end
        inr  = ({1'b0, addr} < 33'(4 * AW));
        widx = int'(addr >> 2);
        if (en && wen != 4'h0 && inr) begin
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) begin
                    mmem[widx][8*b +: 8] = wdata[8*b +: 8];
                    mknown[widx][b] = 1'b1;
                end
            end
        end
        if (reset) begin
            e_acc = 1'b0; e_rd = 0; e_wr = 0; e_err = 0;
            for (int i = 0; i < 3; i++) begin
                for (int k = edge_n; k < MAXE; k++) ev[i][k] = 1'b0;
                e_data[i] = 32'h0;
                e_mask[i] = 4'hf;
            end
        end else if (en) begin
            if (!inr) begin
                e_acc = 1'b1; e_err = e_err + 1;
            end else if (wen != 4'h0) begin
                e_wr = e_wr + 1;
            end else begin
                e_rd = e_rd + 1;
            end
            if (wen == 4'h0) begin
                for (int i = 0; i < 3; i++) begin
                    due = edge_n + i;
                    ev[i][due] = 1'b1;
                    ed[i][due] = inr ? mmem[widx] : 32'h0;
                    em[i][due] = inr ? mknown[widx] : 4'hf;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            e_valid[i] = ev[i][edge_n];
            if (e_valid[i]) begin
                e_data[i] = ed[i][edge_n];
                e_mask[i] = em[i][edge_n];
            end
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("valid_l%0d", i + 1), 32'(valid[i]), 32'(e_valid[i]));
                check($sformatf("rdata_l%0d", i + 1), rdata[i] & bytemask(e_mask[i]),
                      e_data[i] & bytemask(e_mask[i]));
                check($sformatf("acc_err_l%0d", i + 1), 32'(acc_err[i]), 32'(e_acc));
                check($sformatf("rd_cnt_l%0d", i + 1), rd_cnt[i], e_rd);
                check($sformatf("wr_cnt_l%0d", i + 1), wr_cnt[i], e_wr);
                check($sformatf("err_cnt_l%0d", i + 1), err_cnt[i], e_err);
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        reset = r; en = e; wen = w; addr = a; wdata = d;
        @(posedge clk);
        model_edge();
        started = 1;
        #1;
    endtask

    logic [31:0] w3 [3];

    initial begin
        w3[0] = 32'h0101_A0A0; w3[1] = 32'h0202_B1B1; w3[2] = 32'h0303_C2C2;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < MAXE; k++) ev[i][k] = 1'b0;
        end
        for (int k = 0; k < int'(AW); k++) begin
            mmem[k] = 32'h0; mknown[k] = 4'h0;
        end
        reset = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;

        step(1, 0, 4'h0, 32'h0, 32'h0);
        step(1, 0, 4'h0, 32'h0, 32'h0);
        check("reset_valid", 32'(valid[0]), 32'h0);
        check("reset_rdata", rdata[0], 32'h0);
        check("reset_wr_cnt", wr_cnt[2], 32'h0);

        // Full-word write then read
        step(0, 1, 4'hf, 32'h10, 32'hDEAD_BEEF);
        step(0, 1, 4'h0, 32'h10, 32'h0);
        check("t1_rdata", rdata[0], 32'hDEAD_BEEF);
        check("t1_valid", 32'(valid[0]), 32'h1);
        check("t1_wr_cnt", wr_cnt[0], 32'd1);
        check("t1_rd_cnt", rd_cnt[0], 32'd1);

        // Byte lanes
        step(0, 1, 4'hf, 32'h20, 32'h1122_3344);
        step(0, 1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        step(0, 1, 4'h0, 32'h20, 32'h0);
        check("t2_rdata", rdata[0], 32'h11BB_33DD);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        check("t2_rdata_l3", rdata[2], 32'h11BB_33DD);

        // Back-to-back reads through the three-deep pipeline
        for (int j = 0; j < 3; j++) step(0, 1, 4'hf, 32'(4 * j), w3[j]);
        for (int j = 0; j < 6; j++) begin
            step(0, (j < 3), 4'h0, 32'(4 * j), 32'h0);
            check($sformatf("t3_valid_%0d", j), 32'(valid[2]), 32'((j >= 2 && j <= 4) ? 1 : 0));
            if (j >= 2 && j <= 4) check($sformatf("t3_rdata_%0d", j), rdata[2], w3[j-2]);
        end

        // Out-of-range read and write
        step(0, 1, 4'h0, 32'(4 * AW), 32'h0);
        check("t4_rdata", rdata[0], 32'h0);
        check("t4_valid", 32'(valid[0]), 32'h1);
        check("t4_acc_err", 32'(acc_err[0]), 32'h1);
        check("t4_err_cnt", err_cnt[0], 32'd1);
        step(0, 1, 4'hf, 32'(4 * AW), 32'hFFFF_FFFF);
        check("t4_err_cnt2", err_cnt[0], 32'd2);
        step(0, 1, 4'h0, 32'h0, 32'h0);
        check("t4_mem_kept", rdata[0], w3[0]);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        step(0, 0, 4'h0, 32'h0, 32'h0);

        // Reset with a read in flight; a write on a reset edge still lands
        step(0, 1, 4'h0, 32'h10, 32'h0);
        step(1, 1, 4'hf, 32'h30, 32'hCAFE_F00D);
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 4'h0, 32'h0, 32'h0);
            check($sformatf("t5_no_valid_%0d", j), 32'(valid[1]), 32'h0);
        end
        check("t5_rd_cnt", rd_cnt[1], 32'h0);
        check("t5_acc_err", 32'(acc_err[1]), 32'h0);
        step(0, 1, 4'h0, 32'h30, 32'h0);
        check("t5_reset_write", rdata[0], 32'hCAFE_F00D);

        // Low address bits ignored; idle cycles hold data and counters
        step(0, 1, 4'h0, 32'h13, 32'h0);
        check("t6_rdata", rdata[0], 32'hDEAD_BEEF);
        for (int j = 0; j < 4; j++) step(0, 0, 4'h0, 32'h13, 32'h0);
        check("t6_hold", rdata[2], 32'hDEAD_BEEF);
        check("t6_rd_cnt", rd_cnt[0], 32'd2);
        check("t6_hold_valid", 32'(valid[0]), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
